// File: rtl/fp16_pkg.sv
// Shared fp16 constants, flag bit positions and the S1->S2 payload of fp16_norm_pack.
package fp16_pkg;
  localparam int FP16_EXP_BIAS = 15;
  localparam int FP16_EXP_MAX  = 31;
  localparam int FP16_FRAC_W   = 10;

  // out_flags = {overflow, underflow, inexact, zero}
  localparam int FLAG_OVF  = 3;
  localparam int FLAG_UNF  = 2;
  localparam int FLAG_INX  = 1;
  localparam int FLAG_ZERO = 0;

  // sig[13] is the hidden bit after normalization; it is 0 only for a zero input.
  typedef struct packed {
    logic              sign;
    logic signed [7:0] e;
    logic [13:0]       sig;
    logic              sticky;
  } s1_payload_t;
endpackage

// File: rtl/fp16_lzc14.sv
// Combinational 14-bit leading-zero counter; returns 14 for an all-zero input.
module fp16_lzc14 (
  input  logic [13:0] d,
  output logic [3:0]  cnt
);
  logic found;

  always_comb begin
    cnt   = 4'd14;
    found = 1'b0;
    for (int i = 13; i >= 0; i--) begin
      if (!found && d[i]) begin
        cnt   = 4'(13 - i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fp16_norm_pack.sv
// Two-stage normalize / round-to-nearest-even / pack into IEEE binary16 with valid-ready flow.
// Subnormal outputs are produced when FP16_PACK_SUBNORM_EN is defined, otherwise tiny results flush to zero.
module fp16_norm_pack
  import fp16_pkg::*;
#(
  parameter int FRAC_W = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [6:0]  in_exp,
  input  logic [13:0] in_mant,
  input  logic        in_sticky,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_fp16,
  output logic [3:0]  out_flags
);
  localparam int STAGES = 2;
  localparam logic signed [7:0] EXP_MAX_S = 8'(FP16_EXP_MAX);

  logic [STAGES:1] vld_pipe;
  logic            s1_ready, s2_ready;
  logic [3:0]      lz;
  s1_payload_t     s1_d, s1_q;

  assign s2_ready  = !vld_pipe[2] || out_ready;
  assign s1_ready  = !vld_pipe[1] || s2_ready;
  assign in_ready  = s1_ready;
  assign out_valid = vld_pipe[2];

  fp16_lzc14 u_lzc (.d(in_mant), .cnt(lz));

  always_comb begin
    s1_d.sign   = in_sign;
    s1_d.e      = {in_exp[6], in_exp} + 8'd1 - {4'd0, lz};
    s1_d.sig    = in_mant << lz;
    s1_d.sticky = in_sticky;
  end

  // S2: round and pack
  logic signed [7:0] e_n, e_r;
  logic [12:0]       sig_x;
  logic              lost, g, stk, inc, tiny, inexact, carry, is_zero;
  logic [FRAC_W-1:0] frac_r;
  logic [15:0]       fp_d;
  logic [3:0]        fl_d;
`ifdef FP16_PACK_SUBNORM_EN
  logic [7:0]        sh;
  logic [13:0]       mask;
`endif

  always_comb begin
    e_n     = s1_q.e;
    is_zero = !s1_q.sig[13];
    tiny    = (e_n <= 8'sd0);
    sig_x   = s1_q.sig[12:0];
    lost    = 1'b0;
`ifdef FP16_PACK_SUBNORM_EN
    // Denormalize by 1-e; shifts of 14 or more leave nothing but sticky.
    sh   = 8'd1 - e_n;
    mask = (14'd1 << sh) - 14'd1;
    if (tiny) begin
      sig_x = 13'(s1_q.sig >> sh);
      lost  = |(s1_q.sig & mask);
    end
`endif
    g       = sig_x[2];
    stk     = |sig_x[1:0] | s1_q.sticky | lost;
    inc     = g & (stk | sig_x[3]);
    inexact = g | stk;
    {carry, frac_r} = {1'b0, sig_x[12:3]} + {{FRAC_W{1'b0}}, inc};
    e_r     = e_n + {7'd0, carry};

    fp_d = '0;
    fl_d = '0;
    if (is_zero) begin
      fp_d            = {s1_q.sign, 15'h0};
      fl_d[FLAG_ZERO] = 1'b1;
    end else if (tiny) begin
`ifdef FP16_PACK_SUBNORM_EN
      // A carry out of the fraction lands in the exponent LSB: smallest normal.
      fp_d            = {s1_q.sign, 4'd0, carry, frac_r};
      fl_d[FLAG_UNF]  = inexact;
      fl_d[FLAG_INX]  = inexact;
      fl_d[FLAG_ZERO] = !carry && (frac_r == '0);
`else
      fp_d            = {s1_q.sign, 15'h0};
      fl_d[FLAG_UNF]  = 1'b1;
      fl_d[FLAG_INX]  = 1'b1;
      fl_d[FLAG_ZERO] = 1'b1;
`endif
    end else if (e_r >= EXP_MAX_S) begin
      fp_d           = {s1_q.sign, 5'h1F, 10'h0};
      fl_d[FLAG_OVF] = 1'b1;
      fl_d[FLAG_INX] = 1'b1;
    end else begin
      fp_d           = {s1_q.sign, e_r[4:0], frac_r};
      fl_d[FLAG_INX] = inexact;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      s1_q      <= '0;
      out_fp16  <= '0;
      out_flags <= '0;
    end else begin
      if (s1_ready) begin
        vld_pipe[1] <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s2_ready) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          out_fp16  <= fp_d;
          out_flags <= fl_d;
        end
      end
    end
  end
endmodule

// File: doc/fp16_norm_pack.md
FP16_NORM_PACK -- requirements
Module: fp16_norm_pack

Interface
REQ-001 SHALL have parameter FRAC_W, default 10, giving the fp16 fraction width; only 10 is supported.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1, input transfer request.
REQ-005 SHALL have port in_ready, output, 1, input can be accepted; transfer occurs when in_valid && in_ready.
REQ-006 SHALL have port in_sign, input, 1, result sign.
REQ-007 SHALL have port in_exp, input, 7, signed two's-complement biased exponent (bias 15).
REQ-008 SHALL have port in_mant, input, 14, unsigned magnitude with bit13 = 2^1, bit12 = 2^0, bits11:2 = fraction, bits1:0 = extra precision.
REQ-009 SHALL have port in_sticky, input, 1, OR of all bits below in_mant[0].
REQ-010 SHALL have port out_valid, output, 1, result available.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts.
REQ-012 SHALL have port out_fp16, output, 16, packed IEEE binary16 result.
REQ-013 SHALL have port out_flags, output, 4, {overflow, underflow, inexact, zero}.

Function
REQ-014 SHALL interpret the input value as (-1)^in_sign * in_mant/2^12 * 2^(in_exp-15).
REQ-015 SHALL be a 2-stage pipeline: S1 does leading-zero count and left shift; S2 does round and pack. Latency is 2 cycles from input transfer to out_valid with out_ready held high.
REQ-016 SHALL propagate ready per stage as s2_ready = !s2_valid || out_ready, s1_ready = !s1_valid || s2_ready, and in_ready = s1_ready. Throughput is 1 per cycle.
REQ-017 SHALL hold out_fp16 and out_flags stable while out_valid && !out_ready.
REQ-018 S1: L = leading zeros of in_mant; shift in_mant left by L; normalized exponent e = in_exp + 1 - L (8-bit signed).
REQ-019 Field split after the shift: fraction = bits12:3, guard = bit2, sticky = bit1 | bit0 | in_sticky.
REQ-020 SHALL round to nearest, ties to even: increment when guard && (sticky || fraction LSB).
REQ-021 SHALL handle fraction carry-out on rounding by setting fraction to 0 and adding 1 to e.
REQ-022 SHALL output {sign, 5'h1F, 10'h0} when e >= 31 after rounding, and set overflow and inexact.
REQ-023 SHALL output {in_sign, 15'h0} when in_mant == 0, with zero = 1 and all other flags 0.
REQ-024 SHALL set inexact when guard || sticky, or when nonzero bits are lost during the subnormal shift.
REQ-025 SHALL handle e <= 0 per the Configuration section.
REQ-026 SHALL set zero whenever the packed magnitude is 0, including a flushed result.

Reset
REQ-027 SHALL, on rst_n low, clear s1_valid, s2_valid, out_valid, out_fp16 and out_flags immediately, asynchronously.
REQ-028 SHALL discard in-flight data on reset mid-operation; in_ready SHALL be 1 in the first cycle after release.

Configuration
REQ-029 SHALL use macro FP16_PACK_SUBNORM_EN.
REQ-030 With FP16_PACK_SUBNORM_EN defined: when e <= 0, SHALL right-shift the significand by 1-e, OR shifted-out bits into sticky, round per REQ-020, and use exponent field 0, or 1 if rounding carries into the hidden bit. A shift > 12 yields zero. underflow = tiny && inexact.
REQ-031 Without FP16_PACK_SUBNORM_EN: when e <= 0 and in_mant != 0, SHALL output {sign, 15'h0} with underflow = 1, inexact = 1 and zero = 1.

Structure
REQ-032 SHALL take FP16_EXP_BIAS = 15, FP16_EXP_MAX = 31, FP16_FRAC_W = 10, a flag-index localparam set, and a struct for the S1→S2 payload from shared package fp16_pkg.
REQ-033 SHALL instantiate one sub-module, fp16_lzc14: a combinational 14-bit leading-zero counter with a 4-bit count output (14 when the input is 0).

Verification
REQ-034 sign 0, exp 15, mant 0x1000, sticky 0 -> out_fp16 0x3C00, flags 0000, out_valid 2 cycles after transfer.
REQ-035 exp 15, mant 0x2000 -> 0x4000; exp 15, mant 0x1002 -> 0x3C00 with inexact (tie to even); exp 15, mant 0x1006 -> 0x3C02 with inexact.
REQ-036 exp 30, mant 0x1FFE -> 0x7C00, flags 1010; sign 1, mant 0 -> 0x8000, flags 0001.
REQ-037 exp 0, mant 0x1000 -> with macro 0x0200, flags 0000; without macro 0x0000, flags 0111.
REQ-038 Stream 4 back-to-back inputs with out_ready low for 3 cycles: in_ready falls after 2 accepts, output is held stable, and all 4 results emerge in order with none lost or duplicated.
REQ-039 Assert rst_n while both stages are valid: out_valid is 0 immediately, and no stale result appears after release.
